bell_round_ctrl: RTL and testbench

Round sequencer for the two-player bell card game. It deals a card pair each round from an on-chip LFSR, and runs the per-round countdown that sets the score value. It arbitrates the bell keys (keypad code 7 = player A, 9 = player B), judges the press, and emits one signed score delta pair per round. It sits between the keypad decoder and the per-player score accumulators; the win comparator reads the accumulated totals.

---
 rtl/bell_pkg.sv | 35 +++
 rtl/bell_card_lfsr.sv | 48 ++++
 rtl/bell_round_ctrl.sv | 155 +++++++++++++++
 tb/tb_bell_round_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bell_pkg.sv
// Shared types, key codes, score constants and card rule for the bell round
// sequencer. Optional round limit: BELL_ROUND_LIMIT_EN (used by bell_round_ctrl).
package bell_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEAL,
    S_WAIT,
    S_JUDGE,
    S_SCORE,
    S_RELEASE,
    S_GAME_OVER
  } state_t;

  localparam logic [3:0] KEY_A = 4'b0111;
  localparam logic [3:0] KEY_B = 4'b1001;

  localparam logic [7:0] DELTA_PENALTY = 8'hFF;
  localparam logic [7:0] DELTA_BONUS   = 8'h01;

  // A press is right when same colours sum to five, or differing colours show a five.
  function automatic logic is_right(input logic [1:0] c1, input logic [1:0] c2,
                                    input logic [2:0] n1, input logic [2:0] n2);
    logic [3:0] sum;
    sum = {1'b0, n1} + {1'b0, n2};
    return ((c1 == c2) && (sum == 4'd5)) ||
           ((c1 != c2) && ((n1 == 3'd5) || (n2 == 3'd5)));
  endfunction

  // Fold a 3-bit raw field onto the card numbers 1..5.
  function automatic logic [2:0] card_num(input logic [2:0] x);
    return (x < 3'd5) ? (x + 3'd1) : (x - 3'd4);
  endfunction

endpackage

// File: rtl/bell_card_lfsr.sv
// Card dealer: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, shifting left) plus
// registered card decode. Cards update only when step_i is high.
module bell_card_lfsr
  import bell_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_i,
  output logic [1:0] c1_o,
  output logic [1:0] c2_o,
  output logic [2:0] n1_o,
  output logic [2:0] n2_o
);

  logic [7:0] lfsr_q, lfsr_d;
  logic [1:0] c1_q, c2_q;
  logic [2:0] n1_q, n2_q;

  // Next LFSR value: feedback from taps 8,6,5,4 enters at bit 0.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Step the LFSR and latch the decoded cards of the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
      c1_q   <= '0;
      c2_q   <= '0;
      n1_q   <= 3'd1;
      n2_q   <= 3'd1;
    end else if (step_i) begin
      lfsr_q <= lfsr_d;
      c1_q   <= lfsr_d[1:0];
      c2_q   <= lfsr_d[3:2];
      n1_q   <= card_num(lfsr_d[6:4]);
      n2_q   <= card_num({lfsr_d[7], lfsr_d[1], lfsr_d[4]});
    end
  end

  assign c1_o = c1_q;
  assign c2_o = c2_q;
  assign n1_o = n1_q;
  assign n2_o = n2_q;

endmodule

// File: rtl/bell_round_ctrl.sv
// Bell game round sequencer: deal, countdown, key arbitration, judging and
// one score-delta pulse per scored round.
// Optional feature macro: BELL_ROUND_LIMIT_EN (game ends after MAX_ROUNDS scores).
module bell_round_ctrl
  import bell_pkg::*;
#(
  parameter logic [7:0]  COUNT_INIT = 8'd100,
  parameter logic [15:0] TICK_DIV   = 16'd1000,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5,
  parameter logic [7:0]  MAX_ROUNDS = 8'd10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] keypad_in,
  output logic [1:0] c1,
  output logic [1:0] c2,
  output logic [2:0] n1,
  output logic [2:0] n2,
  output logic [7:0] count,
  output logic [7:0] delta_a,
  output logic [7:0] delta_b,
  output logic       delta_valid,
  output logic       busy,
  output logic       game_over
);

  state_t      state_q;
  logic [7:0]  count_q;
  logic [15:0] tick_q;
  logic [7:0]  snap_q;
  logic        who_b_q;
  logic [7:0]  delta_a_q, delta_b_q;
  logic        valid_q;
  logic        press_a, press_b, press;

`ifdef BELL_ROUND_LIMIT_EN
  logic [7:0]  round_q;
`else
  logic        unused_max_rounds;
  assign unused_max_rounds = ^MAX_ROUNDS;
`endif

  assign press_a = (keypad_in == KEY_A);
  assign press_b = (keypad_in == KEY_B);
  assign press   = press_a | press_b;

  bell_card_lfsr #(
    .LFSR_SEED(LFSR_SEED)
  ) u_cards (
    .clk   (clk),
    .rst   (rst),
    .step_i(state_q == S_DEAL),
    .c1_o  (c1),
    .c2_o  (c2),
    .n1_o  (n1),
    .n2_o  (n2)
  );

  // Round FSM with countdown, press latch and registered delta outputs.
  // Deltas are loaded in JUDGE so they are presented during the SCORE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      tick_q    <= '0;
      snap_q    <= '0;
      who_b_q   <= 1'b0;
      delta_a_q <= '0;
      delta_b_q <= '0;
      valid_q   <= 1'b0;
`ifdef BELL_ROUND_LIMIT_EN
      round_q   <= '0;
`endif
    end else begin
      valid_q   <= 1'b0;
      delta_a_q <= '0;
      delta_b_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_DEAL;
        end
        S_DEAL: begin
          count_q <= COUNT_INIT;
          tick_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (press) begin
            // Press beats timeout, including on the cycle count is zero.
            who_b_q <= press_b;
            snap_q  <= count_q;
            state_q <= S_JUDGE;
          end else begin
            if (count_q == 8'd0) state_q <= S_DEAL;
            if (tick_q == TICK_DIV - 16'd1) begin
              tick_q <= '0;
              if (count_q != 8'd0) count_q <= count_q - 8'd1;
            end else begin
              tick_q <= tick_q + 16'd1;
            end
          end
        end
        S_JUDGE: begin
          valid_q <= 1'b1;
          state_q <= S_SCORE;
          if (is_right(c1, c2, n1, n2)) begin
            if (who_b_q) delta_b_q <= snap_q;
            else         delta_a_q <= snap_q;
          end else if (who_b_q) begin
            delta_b_q <= DELTA_PENALTY;
            delta_a_q <= DELTA_BONUS;
          end else begin
            delta_a_q <= DELTA_PENALTY;
            delta_b_q <= DELTA_BONUS;
          end
        end
        S_SCORE: begin
          state_q <= S_RELEASE;
`ifdef BELL_ROUND_LIMIT_EN
          round_q <= round_q + 8'd1;
`endif
        end
        S_RELEASE: begin
          if (!press) begin
`ifdef BELL_ROUND_LIMIT_EN
            state_q <= (round_q >= MAX_ROUNDS) ? S_GAME_OVER : S_DEAL;
`else
            state_q <= S_DEAL;
`endif
          end
        end
        S_GAME_OVER: begin
          state_q <= S_GAME_OVER;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign count       = count_q;
  assign delta_a     = delta_a_q;
  assign delta_b     = delta_b_q;
  assign delta_valid = valid_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_GAME_OVER);

`ifdef BELL_ROUND_LIMIT_EN
  assign game_over = (state_q == S_GAME_OVER);
`else
  assign game_over = 1'b0;
`endif

endmodule

// File: tb/tb_bell_round_ctrl.sv
// Directed bench for bell_round_ctrl with a delta scoreboard and an LFSR/card model.
module tb_bell_round_ctrl;

  localparam logic [7:0]  CI   = 8'd50;
  localparam logic [15:0] TD   = 16'd2;
  localparam logic [7:0]  SEED = 8'h4F;  // first deal gives 8'h9F: c1=c2=3, n1=2, n2=3
  localparam logic [7:0]  MR   = 8'd2;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] keypad_in;
  logic [1:0] c1, c2;
  logic [2:0] n1, n2;
  logic [7:0] count, delta_a, delta_b;
  logic       delta_valid, busy, game_over;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  logic [7:0]  m_lfsr;

  typedef struct {
    logic [7:0]  da;
    logic [7:0]  db;
    int unsigned at;
  } exp_t;
  exp_t sb[$];

  bell_round_ctrl #(
    .COUNT_INIT(CI),
    .TICK_DIV  (TD),
    .LFSR_SEED (SEED),
    .MAX_ROUNDS(MR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .keypad_in  (keypad_in),
    .c1         (c1),
    .c2         (c2),
    .n1         (n1),
    .n2         (n2),
    .count      (count),
    .delta_a    (delta_a),
    .delta_b    (delta_b),
    .delta_valid(delta_valid),
    .busy       (busy),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] m_step(input logic [7:0] v);
    logic fb;
    fb = ^(v & 8'hB8);
    return {v[6:0], fb};
  endfunction

  function automatic logic [2:0] m_num(input logic [2:0] x);
    return 3'((int'(x) % 5) + 1);
  endfunction

  function automatic logic m_right(input logic [7:0] v);
    logic [1:0] a, b;
    int p, q;
    a = v[1:0];
    b = v[3:2];
    p = int'(m_num(v[6:4]));
    q = int'(m_num({v[7], v[1], v[4]}));
    if (a == b) return (p + q) == 5;
    return (p == 5) || (q == 5);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cards(input string tag);
    chk({tag, "_c1"}, 32'(c1), 32'(m_lfsr[1:0]));
    chk({tag, "_c2"}, 32'(c2), 32'(m_lfsr[3:2]));
    chk({tag, "_n1"}, 32'(n1), 32'(m_num(m_lfsr[6:4])));
    chk({tag, "_n2"}, 32'(n2), 32'(m_num({m_lfsr[7], m_lfsr[1], m_lfsr[4]})));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_c1"}, 32'(c1), 0);
    chk({tag, "_c2"}, 32'(c2), 0);
    chk({tag, "_n1"}, 32'(n1), 1);
    chk({tag, "_n2"}, 32'(n2), 1);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_da"}, 32'(delta_a), 0);
    chk({tag, "_db"}, 32'(delta_b), 0);
    chk({tag, "_valid"}, 32'(delta_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_gover"}, 32'(game_over), 0);
  endtask

  task automatic wait_count(input logic [7:0] v, input int budget);
    int n;
    n = 0;
    while (count !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_count", 32'(count), 32'(v));
  endtask

  // Queue the delta pair a press should produce two cycles later.
  task automatic press_expect(input logic is_b, input logic [7:0] snap);
    exp_t e;
    if (m_right(m_lfsr)) begin
      e.da = is_b ? 8'h00 : snap;
      e.db = is_b ? snap : 8'h00;
    end else begin
      e.da = is_b ? 8'h01 : 8'hFF;
      e.db = is_b ? 8'hFF : 8'h01;
    end
    e.at = cyc + 2;
    sb.push_back(e);
  endtask

  // Scoreboard side: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (delta_valid) begin
        chk("pulse_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("delta_a", 32'(delta_a), 32'(e.da));
          chk("delta_b", 32'(delta_b), 32'(e.db));
          chk("pulse_cycle", cyc, e.at);
        end
      end else begin
        chk("delta_idle", 32'({delta_a, delta_b}), 0);
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1;
    start = 1'b0;
    keypad_in = 4'h0;
    repeat (3) @(negedge clk);
    check_reset("reset");

    // Keys and idle time do not leave IDLE.
    rst = 1'b0;
    keypad_in = 4'b0111;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_count", 32'(count), 0);
    keypad_in = 4'h0;

    // Start, first deal.
    m_lfsr = SEED;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("deal_busy", 32'(busy), 1);
    @(negedge clk);
    m_lfsr = m_step(m_lfsr);
    check_cards("deal1");
    chk("deal1_c1_fixed", 32'(c1), 3);
    chk("deal1_n1_fixed", 32'(n1), 2);
    chk("deal1_n2_fixed", 32'(n2), 3);
    chk("deal1_count", 32'(count), 32'(CI));

    // Right press by A at count 40, key held 50 cycles across SCORE.
    wait_count(8'd40, 200);
    keypad_in = 4'b0111;
    press_expect(1'b0, 8'd40);
    repeat (50) @(negedge clk);
    chk("hold_busy", 32'(busy), 1);
    keypad_in = 4'h0;
    @(negedge clk);
    chk("hold_release_count", 32'(count), 40);
    @(negedge clk);
    chk("hold_redeal_count", 32'(count), 32'(CI));
    m_lfsr = m_step(m_lfsr);
    check_cards("deal2");
    chk("gover_tied_low", 32'(game_over), 0);

    // Timeout: count falls one step every TD cycles, then a fresh deal.
    for (int i = 0; i < 102; i++) begin
      int e;
      e = (i / int'(TD) < int'(CI)) ? int'(CI) - i / int'(TD) : 0;
      chk("timeout_count", 32'(count), 32'(e));
      @(negedge clk);
    end
    chk("timeout_redeal_count", 32'(count), 32'(CI));
    m_lfsr = m_step(m_lfsr);
    check_cards("deal3");

    // Skip to a wrong-card deal, then B presses wrongly.
    guard = 0;
    while (m_right(m_lfsr) && guard < 20) begin
      wait_count(8'd0, 300);
      repeat (2) @(negedge clk);
      m_lfsr = m_step(m_lfsr);
      check_cards("skip");
      guard++;
    end
    wait_count(8'd20, 200);
    keypad_in = 4'b1001;
    press_expect(1'b1, 8'd20);
    @(negedge clk);
    keypad_in = 4'h0;
    repeat (4) @(negedge clk);
`ifdef BELL_ROUND_LIMIT_EN
    chk("limit1_gover", 32'(game_over), 1);
    chk("limit1_busy", 32'(busy), 0);
`else
    chk("b_redeal_count", 32'(count), 32'(CI));
    m_lfsr = m_step(m_lfsr);
    check_cards("deal4");
    chk("gover_tied_low2", 32'(game_over), 0);
`endif

    // Reset taken in the middle of WAIT.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_count(8'd30, 200);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midwait_reset");
    rst = 1'b0;

    // Restart; A presses on the cycle count reaches zero.
    m_lfsr = SEED;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    m_lfsr = m_step(m_lfsr);
    check_cards("restart");
    wait_count(8'd0, 300);
    keypad_in = 4'b0111;
    press_expect(1'b0, 8'd0);
    @(negedge clk);
    keypad_in = 4'h0;
    chk("zero_press_count", 32'(count), 0);
    repeat (4) @(negedge clk);
    chk("zero_redeal_count", 32'(count), 32'(CI));
    m_lfsr = m_step(m_lfsr);
    check_cards("restart2");

    // Second scored round after restart.
    wait_count(8'd10, 200);
    keypad_in = 4'b1001;
    press_expect(1'b1, 8'd10);
    @(negedge clk);
    keypad_in = 4'h0;
    repeat (4) @(negedge clk);
`ifdef BELL_ROUND_LIMIT_EN
    chk("limit2_gover", 32'(game_over), 1);
    chk("limit2_busy", 32'(busy), 0);
    keypad_in = 4'b0111;
    repeat (6) @(negedge clk);
    keypad_in = 4'h0;
    repeat (2) @(negedge clk);
    chk("limit2_gover_hold", 32'(game_over), 1);
    chk("limit2_count_hold", 32'(count), 10);
`else
    chk("r2_redeal_count", 32'(count), 32'(CI));
    chk("gover_tied_low3", 32'(game_over), 0);
    chk("r2_busy", 32'(busy), 1);
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
